// File: rtl/timer_multi_if.sv
// Register-bus interface for timer_multi.
// Signals (named from the slave's point of view):
//   req_i    access strobe, one cycle per access
//   we_i     1 = write, 0 = read
//   addr_i   word address
//   wdata_i  write data
//   rdata_o  read data, valid with rvalid_o
//   rvalid_o pulses one cycle after every req_i
interface timer_multi_if #(
    parameter int unsigned ADDR_W = 6
);
    logic              req_i;
    logic              we_i;
    logic [ADDR_W-1:0] addr_i;
    logic [31:0]       wdata_i;
    logic [31:0]       rdata_o;
    logic              rvalid_o;

    modport master (
        output req_i, we_i, addr_i, wdata_i,
        input  rdata_o, rvalid_o
    );

    modport slave (
        input  req_i, we_i, addr_i, wdata_i,
        output rdata_o, rvalid_o
    );
endinterface

// File: rtl/timer_multi.sv
// Multi-channel programmable interval timer.
// NCH up-counters of WIDTH bits share one prescaler; each channel has a
// limit, periodic/one-shot mode, sticky pending flag and interrupt enable.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   bus          register bus (slave modport), 1-cycle registered response
//   irq_vec_o    per-channel pending & irq_en, registered
//   irq_o        OR of the per-channel interrupts, registered
module timer_multi #(
    parameter int unsigned NCH    = 4,
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned PSC_W  = 8,
    parameter int unsigned ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    timer_multi_if.slave      bus,
    output logic [NCH-1:0]    irq_vec_o,
    output logic              irq_o
);

    localparam int unsigned FW = ADDR_W - 2;
    localparam logic [ADDR_W-1:0] A_PSC    = ADDR_W'(0);
    localparam logic [ADDR_W-1:0] A_STATUS = ADDR_W'(1);
    localparam logic [1:0] R_CTRL  = 2'd0;
    localparam logic [1:0] R_LIMIT = 2'd1;
    localparam logic [1:0] R_COUNT = 2'd2;

    logic [PSC_W-1:0] psc_q, psc_d;
    logic [PSC_W-1:0] psc_cnt_q, psc_cnt_d;
    logic [NCH-1:0]   en_q, en_d;
    logic [NCH-1:0]   oneshot_q, oneshot_d;
    logic [NCH-1:0]   irq_en_q, irq_en_d;
    logic [NCH-1:0]   pending_q, pending_d;
    logic [WIDTH-1:0] limit_q [NCH];
    logic [WIDTH-1:0] limit_d [NCH];
    logic [WIDTH-1:0] count_q [NCH];
    logic [WIDTH-1:0] count_d [NCH];
    logic [31:0]      rdata_q, rdata_d;
    logic             rvalid_q;
    logic [NCH-1:0]   irq_vec_q, irq_vec_d;
    logic             irq_q;

    logic           wr;
    logic           rd;
    logic           tick;
    logic [FW-1:0]  afield;
    logic [1:0]     asub;
    logic [NCH-1:0] ch_hit;

    assign wr     = bus.req_i & bus.we_i;
    assign rd     = bus.req_i & ~bus.we_i;
    assign afield = bus.addr_i[ADDR_W-1:2];
    assign asub   = bus.addr_i[1:0];
    assign tick   = (psc_cnt_q == psc_q);

    // Channel c occupies word addresses 4+4c .. 7+4c
    always_comb begin : chan_decode
        ch_hit = '0;
        for (int unsigned c = 0; c < NCH; c++) begin
            ch_hit[c] = (afield == FW'(c + 1));
        end
    end

    // Prescaler, channel counters and register writes
    always_comb begin : next_state
        psc_d     = psc_q;
        psc_cnt_d = tick ? '0 : psc_cnt_q + PSC_W'(1);
        en_d      = en_q;
        oneshot_d = oneshot_q;
        irq_en_d  = irq_en_q;
        limit_d   = limit_q;
        count_d   = count_q;
        pending_d = pending_q;

        if (wr && bus.addr_i == A_PSC) begin
            psc_d     = PSC_W'(bus.wdata_i);
            psc_cnt_d = '0;
        end
        // W1C applied before the expiry set so a same-cycle expiry wins
        if (wr && bus.addr_i == A_STATUS) begin
            pending_d = pending_q & ~NCH'(bus.wdata_i);
        end

        for (int unsigned c = 0; c < NCH; c++) begin
            // A COUNT write suppresses that cycle's increment/expiry
            if (tick && en_q[c] && !(wr && ch_hit[c] && asub == R_COUNT)) begin
                if (count_q[c] >= limit_q[c]) begin
                    count_d[c]   = '0;
                    pending_d[c] = 1'b1;
                    if (oneshot_q[c]) en_d[c] = 1'b0;
                end else begin
                    count_d[c] = count_q[c] + WIDTH'(1);
                end
            end
            if (wr && ch_hit[c] && asub == R_COUNT) count_d[c] = WIDTH'(bus.wdata_i);
            if (wr && ch_hit[c] && asub == R_LIMIT) limit_d[c] = WIDTH'(bus.wdata_i);
            // Written CTRL overrides a same-cycle one-shot disable
            if (wr && ch_hit[c] && asub == R_CTRL) begin
                en_d[c]      = bus.wdata_i[0];
                oneshot_d[c] = bus.wdata_i[1];
                irq_en_d[c]  = bus.wdata_i[2];
            end
        end

        irq_vec_d = pending_q & irq_en_q;
    end

    // Read mux sees pre-update register values
    always_comb begin : read_mux
        rdata_d = '0;
        if (rd) begin
            if (bus.addr_i == A_PSC) begin
                rdata_d = 32'(psc_q);
            end else if (bus.addr_i == A_STATUS) begin
                rdata_d = 32'(pending_q);
            end else begin
                for (int unsigned c = 0; c < NCH; c++) begin
                    if (ch_hit[c]) begin
                        case (asub)
                            R_CTRL:  rdata_d = 32'({irq_en_q[c], oneshot_q[c], en_q[c]});
                            R_LIMIT: rdata_d = 32'(limit_q[c]);
                            R_COUNT: rdata_d = 32'(count_q[c]);
                            default: rdata_d = '0;
                        endcase
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin : regs
        if (!rst_n) begin
            psc_q     <= '0;
            psc_cnt_q <= '0;
            en_q      <= '0;
            oneshot_q <= '0;
            irq_en_q  <= '0;
            pending_q <= '0;
            for (int unsigned c = 0; c < NCH; c++) begin
                limit_q[c] <= '0;
                count_q[c] <= '0;
            end
            rdata_q   <= '0;
            rvalid_q  <= 1'b0;
            irq_vec_q <= '0;
            irq_q     <= 1'b0;
        end else begin
            psc_q     <= psc_d;
            psc_cnt_q <= psc_cnt_d;
            en_q      <= en_d;
            oneshot_q <= oneshot_d;
            irq_en_q  <= irq_en_d;
            pending_q <= pending_d;
            limit_q   <= limit_d;
            count_q   <= count_d;
            rdata_q   <= rdata_d;
            rvalid_q  <= bus.req_i;
            irq_vec_q <= irq_vec_d;
            irq_q     <= |irq_vec_d;
        end
    end

    assign bus.rdata_o  = rdata_q;
    assign bus.rvalid_o = rvalid_q;
    assign irq_vec_o    = irq_vec_q;
    assign irq_o        = irq_q;

endmodule

// File: doc/timer_multi.md
Name: timer_multi

Overview:
- Multi-channel programmable interval timer. Generalised successor of the fixed-period free-running timer.
- NCH independent up-counters of WIDTH bits share one programmable prescaler.
- Each channel has a runtime limit, periodic or one-shot mode, a sticky pending flag and an interrupt enable.
- Sits on the peripheral register bus. Drives a per-channel interrupt vector and a combined interrupt line to the core.

Parameters:
NCH, 4, number of timer channels (1..8)
WIDTH, 32, counter/limit width in bits (8..32)
PSC_W, 8, prescaler width; tick period = PSC+1 clk cycles
ADDR_W, 6, word-address width of register port; must satisfy 4+4*NCH <= 2**ADDR_W

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
req_i  in  1  register access strobe, one cycle per access
we_i  in  1  1 = write, 0 = read
addr_i  in  ADDR_W  word address
wdata_i  in  32  write data
rdata_o  out  32  read data, valid when rvalid_o=1
rvalid_o  out  1  pulses 1 cycle after every req_i (reads and writes)
irq_vec_o  out  NCH  per-channel pending & irq_en, registered
irq_o  out  1  OR of irq_vec_o, registered

Behaviour:
- Reset: all state 0. rdata_o=0, rvalid_o=0, irq_vec_o=0, irq_o=0. PSC=0, all channels disabled, LIMIT=0, COUNT=0, pending=0.
- Register map (word addresses):
  - 0: PSC [PSC_W-1:0], RW.
  - 1: STATUS [NCH-1:0] pending bits. Read; write-1-to-clear.
  - 4+4*c: CTRL of channel c. bit0 en, bit1 oneshot, bit2 irq_en. RW.
  - 5+4*c: LIMIT, RW.
  - 6+4*c: COUNT, RW.
  - Unmapped reads return 0; unmapped writes are ignored. Unused upper bits read 0.
- Bus timing: rdata_o/rvalid_o are registered, 1-cycle latency, no wait states. A write takes effect at the clock edge ending the req_i cycle. A read returns the value before any same-cycle update.
- Prescaler:
  - psc_cnt counts 0..PSC freely. tick=1 in the cycle psc_cnt==PSC, then psc_cnt wraps to 0.
  - PSC=0 gives tick every cycle.
  - A write to PSC forces psc_cnt to 0 on the same edge.
- Channel counting: on tick with en=1:
  - if COUNT >= LIMIT: expiry. COUNT←0 and pending←1. If oneshot=1, en←0.
  - else COUNT←COUNT+1.
  - Periodic expiry therefore occurs every (LIMIT+1)*(PSC+1) clk cycles.
  - The >= comparison means lowering LIMIT below the current COUNT expires at the next tick; there is no runaway wrap.
  - en=0 freezes COUNT. Enabling does not clear COUNT.
- irq_vec_o[c] = registered (pending[c] & irq_en[c]). It appears 1 cycle after pending sets, i.e. 2 edges after the expiry tick cycle. irq_o is registered in the same cycle as irq_vec_o.
- Simultaneous events:
  - W1C of pending in the same cycle as an expiry: set wins, pending stays 1.
  - COUNT write in a tick cycle: the write wins; no increment and no expiry that cycle.
  - CTRL write in a tick cycle: the written en/oneshot take effect. The tick's count/expiry uses the old en. If old en=1 and the expiry is one-shot, the written en value still wins.
  - LIMIT write in a tick cycle: the compare uses the old LIMIT.
- LIMIT=0: expiry on every tick.
- Counter arithmetic is WIDTH-bit unsigned. COUNT can never exceed LIMIT through counting.
- Reset asserted mid-operation returns everything to reset values immediately (asynchronous). Counting resumes only after software re-enables.

Test Plan:
- Reset, then read addr 0,1,4,5,6 -> all rdata 0; rvalid_o pulses exactly 1 cycle after each req_i.
- PSC=0, ch0 LIMIT=4, CTRL=0b101 -> pending[0] sets every 5 cycles; irq_o rises 1 cycle after pending; COUNT sequence 0,1,2,3,4,0.
- PSC=3, ch1 LIMIT=2, CTRL=0b111 (oneshot) -> single expiry 12 cycles after enable; CTRL reads 0b110 afterwards; COUNT held at 0.
- Ch0 running with COUNT=7, write LIMIT=3 -> expiry on the next tick; COUNT becomes 0; no wrap through 2**WIDTH.
- Write STATUS=1 in the exact cycle of a ch0 expiry -> pending[0] stays 1. Write STATUS=1 one cycle later -> pending[0]=0, irq_o falls next cycle.
- Assert rst_n low mid-count with irq_o=1 -> irq_o, irq_vec_o, COUNT, CTRL go 0 asynchronously; no expiry after release until re-enabled.
